fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the control decoder. Holds the PC,
//  runs a req/ack handshake with instruction memory and presents one instruction per
//  cycle (if_instr, if_opcode = if_instr[15:11]) to decode.
//  Back-pressure from decode is absorbed by a 1-entry skid buffer. Branch/jump
//  redirects flush the stage. Fetch stops permanently once decode accepts a HALT.
// PARAMETERS
//  PC_W      16       PC / memory address width
//  INSTR_W   16       instruction width
//  RESET_PC  16'h0000 first fetch address after reset
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  imem_req       out  1        fetch request to instruction memory
//  imem_addr      out  PC_W     fetch address, from req_addr register
//  imem_ack       in   1        memory response valid; may arrive in the same cycle as req
//  imem_rdata     in   INSTR_W  instruction data, valid when imem_ack=1
//  stall          in   1        decode cannot accept the current if_* contents
//  redirect_valid in   1        1-cycle pulse: taken branch/jump resolved downstream
//  redirect_pc    in   PC_W     new fetch address, valid with redirect_valid
//  halt           in   1        decoder Halt flag for the current if_opcode
//  if_valid       out  1        if_* outputs hold a live instruction
//  if_instr       out  INSTR_W  instruction to decode
//  if_opcode      out  5        if_instr[15:11]
//  if_pc          out  PC_W     address of if_instr
//  if_pc_plus2    out  PC_W     if_pc + 2, mod 2^PC_W
//  halted         out  1        fetch stopped; only rst_n exits
// BEHAVIOUR
//  Reset values (rst_n=0):
//   - state=START, pc=req_addr=RESET_PC
//   - if_valid=0, if_instr=16'h0800 (NOP), if_pc=0, if_pc_plus2=0
//   - skid empty, imem_req=0, halted=0
//  Handshake:
//   - A transfer completes on a cycle with imem_req=1 and imem_ack=1.
//   - Once imem_req is raised, it and imem_addr stay stable until that transfer completes.
//  accept = !if_valid || !stall. Output register loads only when accept=1.
//  Each load sets if_pc=addr and if_pc_plus2=addr+2. pc increments by 2 per completed transfer, wrapping.
//  States (imem_req=1 in REQ, FLUSH, DRAIN only):
//   START : 1 cycle after reset release -> REQ, req_addr=pc.
//   REQ   : on ack & accept -> load output, stay REQ at pc+2 (1 instr/cycle with 0-wait memory).
//           on ack & !accept -> data to skid, -> BUF.
//           no ack & accept & if_valid -> if_valid=0.
//   BUF   : req=0. When !stall -> skid moves to output, -> REQ.
//   FLUSH : wait for ack of the outstanding wrong-path request, discard data, -> REQ at pc.
//   DRAIN : wait for ack, discard data, -> HALTED.
//   HALTED: req=0, if_valid=0, halted=1.
//  Redirect (any state except DRAIN/HALTED, where it is ignored):
//   - pc=redirect_pc; if_valid=0 and if_instr=NOP next cycle; skid cleared.
//   - REQ with ack in the same cycle -> data dropped, stay REQ, imem_addr=redirect_pc next cycle.
//   - REQ without ack -> FLUSH. FLUSH -> stays FLUSH, pc updated. BUF/START -> REQ.
//  Halt accept = if_valid & halt & !stall:
//   - if_valid=0; REQ -> DRAIN (ack in the same cycle -> HALTED); BUF -> HALTED, skid dropped.
//  Simultaneous redirect + halt accept: redirect wins (the HALT is on the wrong path).
//  Simultaneous ack + redirect: redirect wins, data discarded.
//  rst_n asserted mid-transfer: all state returns to reset values immediately.
//  An ack arriving after reset release with imem_req=0 is ignored.
// TESTING
//  Reset release, 0-wait memory returning mem[a]=a|16'h4000:
//   -> START, then if_valid from cycle 3; if_pc 0,2,4,... one per cycle.
//  stall=1 for 3 cycles while REQ acks addr 6:
//   -> addr 6 held in skid with req=0; if_* frozen at addr 4; addr 6 appears 1 cycle after stall drops, no loss/duplication.
//  redirect_pc=16'h0100 while REQ at addr 8 is unacked and ack comes 2 cycles later:
//   -> FLUSH; addr 8 data discarded; next imem_addr=16'h0100; if_valid=0 until 16'h0100 returns.
//  PC wrap, RESET_PC=16'hFFFC:
//   -> if_pc sequence FFFC, FFFE, 0000; if_pc_plus2 for FFFE = 16'h0000.
//  HALT (opcode 00000) at if_pc=16'h0010 with an outstanding req:
//   -> DRAIN until ack, then halted=1, imem_req=0 forever; redirect_valid ignored.
//  rst_n low mid-FLUSH:
//   -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the control decoder.
// Keeps the PC and runs a req/ack handshake with instruction memory.
// Presents one instruction per cycle to decode.
// A 1-entry skid buffer absorbs decode back-pressure.
// Redirects flush the stage, and an accepted HALT stops fetch until reset.
module fetch_unit #(
  parameter int                PC_W     = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [4:0]         if_opcode,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus2,
  output logic               halted
);

  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_BUF    = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h0800);
  localparam logic [PC_W-1:0]    PC_STEP   = PC_W'(2);

  logic [2:0]         state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    req_addr;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic               accept;
  logic               halt_accept;
  logic               redirect_taken;
  logic [PC_W-1:0]    pc_next;

  // Memory request is held high only in the states that own an outstanding fetch.
  assign imem_req  = (state == S_REQ) || (state == S_FLUSH) || (state == S_DRAIN);
  assign imem_addr = req_addr;
  assign halted    = (state == S_HALTED);
  assign if_opcode = if_instr[INSTR_W-1 -: 5];

  // Decode-side qualifiers.
  // A redirect is ignored once fetch is draining or stopped.
  assign accept         = !if_valid || !stall;
  assign halt_accept    = if_valid && halt && !stall;
  assign redirect_taken = redirect_valid && (state != S_DRAIN) && (state != S_HALTED);
  assign pc_next        = pc + PC_STEP;

  // Fetch FSM, output register and skid buffer, all updated together.
  // Redirect has priority over halt acceptance, and both have priority over new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_START;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
    end else begin
      if (redirect_taken) begin
        pc         <= redirect_pc;
        if_valid   <= 1'b0;
        if_instr   <= NOP_INSTR;
        skid_valid <= 1'b0;
      end
      case (state)
        S_START: begin
          req_addr <= redirect_taken ? redirect_pc : pc;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (redirect_taken) begin
            if (imem_ack) begin
              req_addr <= redirect_pc;
            end else begin
              state <= S_FLUSH;
            end
          end else if (halt_accept) begin
            if_valid <= 1'b0;
            state    <= imem_ack ? S_HALTED : S_DRAIN;
          end else if (imem_ack) begin
            pc       <= pc_next;
            req_addr <= pc_next;
            if (accept) begin
              if_valid    <= 1'b1;
              if_instr    <= imem_rdata;
              if_pc       <= req_addr;
              if_pc_plus2 <= req_addr + PC_STEP;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= req_addr;
              state      <= S_BUF;
            end
          end else if (accept && if_valid) begin
            if_valid <= 1'b0;
          end
        end
        S_BUF: begin
          if (redirect_taken) begin
            req_addr <= redirect_pc;
            state    <= S_REQ;
          end else if (halt_accept) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            state      <= S_HALTED;
          end else if (!stall) begin
            if_valid    <= skid_valid;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus2 <= skid_pc + PC_STEP;
            skid_valid  <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_FLUSH: begin
          if (imem_ack) begin
            req_addr <= redirect_taken ? redirect_pc : pc;
            state    <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            state <= S_HALTED;
          end
        end
        S_HALTED: begin
          if_valid <= 1'b0;
        end
        default: begin
          state <= S_START;
        end
      endcase
    end
  end

endmodule
